// File: rtl/bus_pkg.sv
// Shared definitions for the core memory-bus decoder.
//   - state_e        : response sequencer FSM states
//   - DEF_*          : default address map and error read data
//   - SEL_*_BIT      : bit positions of the one-hot decode result {ram, acc, err}
//   - in_window()    : full 32-bit base/size window test
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RAM  = 3'd1,
        ST_ACC  = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [31:0] DEF_RAM_BASE = 32'h0080_0000;
    localparam int          DEF_RAM_AW   = 16;
    localparam logic [31:0] DEF_ACC_BASE = 32'h0200_0000;
    localparam int          ACC_AW       = 12;   // 4 KiB register window
    localparam int          DEF_TIMEOUT  = 256;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    localparam int SEL_RAM_BIT = 2;
    localparam int SEL_ACC_BIT = 1;
    localparam int SEL_ERR_BIT = 0;

    // Compare in 33 bits so a window touching the top of the address space
    // does not wrap its upper bound to zero.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          aw);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'd1 << aw);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder for the core memory bus.
// Ports:
//   addr in 32 : byte address from the core (bits [1:0] have no effect since
//                both windows are word aligned)
//   sel  out 3 : one-hot {ram, acc, err}; err is set when no window matches
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [31:0] ACC_BASE = DEF_ACC_BASE
) (
    input  logic [31:0] addr,
    output logic [2:0]  sel
);

    logic ram_hit;
    logic acc_hit;

    always_comb begin
        ram_hit = in_window(addr, RAM_BASE, RAM_AW);
        acc_hit = in_window(addr, ACC_BASE, ACC_AW);
        sel = '0;
        // RAM takes priority so the result stays one-hot even if a
        // misconfigured map makes the windows overlap.
        sel[SEL_RAM_BIT] = ram_hit;
        sel[SEL_ACC_BIT] = acc_hit & ~ram_hit;
        sel[SEL_ERR_BIT] = ~ram_hit & ~acc_hit;
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// Address decoder and response sequencer for the core's native memory bus.
// Routes each transfer to the program/data RAM or the matmul accelerator
// window and returns exactly one cpu_mem_ready pulse per transfer. Unmapped
// addresses complete with rdata 0 and set the sticky bus_err flag.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : a slave that does not answer within TIMEOUT cycles is
//               abandoned and the transfer completes with ERR_DATA + bus_err
//   undefined : slaves may stall indefinitely
//
// Ports:
//   clk, resetn (async, active low)
//   cpu_mem_*  : core request (valid/instr/addr/wdata/wstrb) and response
//                (ready pulse, rdata held between pulses)
//   ram_*      : RAM slave port, word-indexed address
//   acc_*      : accelerator slave port, word-indexed address
//   bus_err    : sticky error flag; bus_err_addr holds the first faulting address
module mem_bus_decoder
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [31:0] ACC_BASE = DEF_ACC_BASE,
    parameter int          TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cpu_mem_valid,
    input  logic              cpu_mem_instr,
    input  logic [31:0]       cpu_mem_addr,
    input  logic [31:0]       cpu_mem_wdata,
    input  logic [3:0]        cpu_mem_wstrb,
    output logic              cpu_mem_ready,
    output logic [31:0]       cpu_mem_rdata,

    output logic              ram_valid,
    output logic [RAM_AW-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic              ram_ready,
    input  logic [31:0]       ram_rdata,

    output logic              acc_valid,
    output logic [9:0]        acc_addr,
    output logic [31:0]       acc_wdata,
    output logic [3:0]        acc_wstrb,
    input  logic              acc_ready,
    input  logic [31:0]       acc_rdata,

    output logic              bus_err,
    output logic [31:0]       bus_err_addr
);

    logic [2:0] sel;

    bus_addr_decode #(
        .RAM_BASE (RAM_BASE),
        .RAM_AW   (RAM_AW),
        .ACC_BASE (ACC_BASE)
    ) u_decode (
        .addr (cpu_mem_addr),
        .sel  (sel)
    );

    state_e            state_q,        state_d;
    logic              ready_q,        ready_d;
    logic [31:0]       rdata_q,        rdata_d;
    logic              ram_valid_q,    ram_valid_d;
    logic [RAM_AW-3:0] ram_addr_q,     ram_addr_d;
    logic [31:0]       ram_wdata_q,    ram_wdata_d;
    logic [3:0]        ram_wstrb_q,    ram_wstrb_d;
    logic              acc_valid_q,    acc_valid_d;
    logic [9:0]        acc_addr_q,     acc_addr_d;
    logic [31:0]       acc_wdata_q,    acc_wdata_d;
    logic [3:0]        acc_wstrb_q,    acc_wstrb_d;
    logic              bus_err_q,      bus_err_d;
    logic [31:0]       bus_err_addr_q, bus_err_addr_d;
    logic              fault;

    // Instruction fetches decode exactly like data accesses.
    logic unused_instr;
    assign unused_instr = cpu_mem_instr;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        expired;
    assign expired = (cnt_q == 16'(TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_DATA, TIMEOUT[15:0]};
`endif

    always_comb begin
        state_d        = state_q;
        ready_d        = 1'b0;
        rdata_d        = rdata_q;
        ram_valid_d    = ram_valid_q;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        ram_wstrb_d    = ram_wstrb_q;
        acc_valid_d    = acc_valid_q;
        acc_addr_d     = acc_addr_q;
        acc_wdata_d    = acc_wdata_q;
        acc_wstrb_d    = acc_wstrb_q;
        bus_err_d      = bus_err_q;
        bus_err_addr_d = bus_err_addr_q;
        fault          = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_mem_valid) begin
                    if (sel[SEL_RAM_BIT]) begin
                        state_d     = ST_RAM;
                        ram_valid_d = 1'b1;
                        ram_addr_d  = cpu_mem_addr[RAM_AW-1:2];
                        ram_wdata_d = cpu_mem_wdata;
                        ram_wstrb_d = cpu_mem_wstrb;
                    end else if (sel[SEL_ACC_BIT]) begin
                        state_d     = ST_ACC;
                        acc_valid_d = 1'b1;
                        acc_addr_d  = cpu_mem_addr[ACC_AW-1:2];
                        acc_wdata_d = cpu_mem_wdata;
                        acc_wstrb_d = cpu_mem_wstrb;
                    end else begin
                        state_d = ST_ERR;
                    end
`ifdef BUS_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end

            ST_RAM: begin
                if (ram_ready) begin
                    ram_valid_d = 1'b0;
                    rdata_d     = ram_rdata;
                    ready_d     = 1'b1;
                    state_d     = ST_DONE;
`ifdef BUS_TIMEOUT_EN
                end else if (expired) begin
                    ram_valid_d = 1'b0;
                    rdata_d     = ERR_DATA;
                    ready_d     = 1'b1;
                    fault       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end

            ST_ACC: begin
                if (acc_ready) begin
                    acc_valid_d = 1'b0;
                    rdata_d     = acc_rdata;
                    ready_d     = 1'b1;
                    state_d     = ST_DONE;
`ifdef BUS_TIMEOUT_EN
                end else if (expired) begin
                    acc_valid_d = 1'b0;
                    rdata_d     = ERR_DATA;
                    ready_d     = 1'b1;
                    fault       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end

            // Unmapped: the write (if any) is simply dropped.
            ST_ERR: begin
                rdata_d = '0;
                ready_d = 1'b1;
                fault   = 1'b1;
                state_d = ST_DONE;
            end

            // The core is still holding valid for the transfer just
            // completed; skip it so it is not decoded a second time.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fault) begin
            bus_err_d = 1'b1;
            if (!bus_err_q) begin
                bus_err_addr_d = cpu_mem_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b0;
            rdata_q        <= '0;
            ram_valid_q    <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            ram_wstrb_q    <= '0;
            acc_valid_q    <= 1'b0;
            acc_addr_q     <= '0;
            acc_wdata_q    <= '0;
            acc_wstrb_q    <= '0;
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            rdata_q        <= rdata_d;
            ram_valid_q    <= ram_valid_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            ram_wstrb_q    <= ram_wstrb_d;
            acc_valid_q    <= acc_valid_d;
            acc_addr_q     <= acc_addr_d;
            acc_wdata_q    <= acc_wdata_d;
            acc_wstrb_q    <= acc_wstrb_d;
            bus_err_q      <= bus_err_d;
            bus_err_addr_q <= bus_err_addr_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign cpu_mem_ready = ready_q;
    assign cpu_mem_rdata = rdata_q;
    assign ram_valid     = ram_valid_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_wstrb     = ram_wstrb_q;
    assign acc_valid     = acc_valid_q;
    assign acc_addr      = acc_addr_q;
    assign acc_wdata     = acc_wdata_q;
    assign acc_wstrb     = acc_wstrb_q;
    assign bus_err       = bus_err_q;
    assign bus_err_addr  = bus_err_addr_q;

endmodule
